// File: rtl/drop_timer.sv
// Gravity-drop scheduler for the falling piece. It counts 1 ms ticks and raises drop_req
// (req/ack handshake) or a one-cycle lock_req pulse. DROP_TIMER_STATS_EN adds drops_total.
module drop_timer #(
  parameter int LEVEL_W = 4,
  parameter int BASE_MS = 1000,
  parameter int STEP_MS = 75,
  parameter int MIN_MS  = 100,
  parameter int SOFT_MS = 50,
  parameter int LOCK_MS = 500
) (
  input  logic               clk50,
  input  logic               rst_n,
  input  logic               tick1k,
  input  logic               run,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               landed,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               lock_req
`ifdef DROP_TIMER_STATS_EN
  ,
  output logic [15:0]        drops_total
`endif
);

  typedef enum logic [1:0] {IDLE, COUNT, REQ, LOCK} state_t;

  state_t      state, state_n;
  logic [15:0] ms_cnt, ms_cnt_n;
  logic        lock_req_n;
  logic [31:0] lv_prod;
  logic [15:0] lv_ms, iv, cnt_inc;
  logic        counted;

  // Level-scaled interval goes to 0 instead of wrapping when the product exceeds the base.
  function automatic logic [15:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 16'd0 : d[15:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  always_comb begin
    lv_prod = 32'(level) * 32'(STEP_MS);
    lv_ms   = sat_sub(32'(BASE_MS), lv_prod);
    iv      = (lv_ms < 16'(MIN_MS)) ? 16'(MIN_MS) : lv_ms;
    if (soft_drop && (iv > 16'(SOFT_MS)))
      iv = 16'(SOFT_MS);
  end

  assign cnt_inc  = ms_cnt + 16'd1;
  assign counted  = tick1k && !pause;
  assign drop_req = (state == REQ);

  // Pause freezes every transition except the run-low override.
  always_comb begin
    state_n    = state;
    ms_cnt_n   = ms_cnt;
    lock_req_n = 1'b0;
    unique case (state)
      IDLE: begin
        ms_cnt_n = 16'd0;
        if (run) state_n = COUNT;
      end
      COUNT: begin
        if (!pause && landed) begin
          state_n  = LOCK;
          ms_cnt_n = 16'd0;
        end else if (counted) begin
          if (cnt_inc >= iv) begin
            state_n  = REQ;
            ms_cnt_n = 16'd0;
          end else begin
            ms_cnt_n = cnt_inc;
          end
        end
      end
      REQ: begin
        if (!pause && drop_ack) begin
          state_n  = COUNT;
          ms_cnt_n = 16'd0;
        end
      end
      LOCK: begin
        if (!pause && !landed) begin
          state_n  = COUNT;
          ms_cnt_n = 16'd0;
        end else if (counted) begin
          if (cnt_inc >= 16'(LOCK_MS)) begin
            lock_req_n = 1'b1;
            state_n    = COUNT;
            ms_cnt_n   = 16'd0;
          end else begin
            ms_cnt_n = cnt_inc;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        ms_cnt_n = 16'd0;
      end
    endcase
    if (!run) begin
      state_n    = IDLE;
      ms_cnt_n   = 16'd0;
      lock_req_n = 1'b0;
    end
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      state    <= IDLE;
      ms_cnt   <= 16'd0;
      lock_req <= 1'b0;
    end else begin
      state    <= state_n;
      ms_cnt   <= ms_cnt_n;
      lock_req <= lock_req_n;
    end
  end

`ifdef DROP_TIMER_STATS_EN
  logic ack_taken;
  assign ack_taken = (state == REQ) && (state_n == COUNT);

  always_ff @(posedge clk50) begin
    if (!rst_n)
      drops_total <= 16'd0;
    else if (state_n == IDLE)
      drops_total <= 16'd0;
    else if (ack_taken)
      drops_total <= sat_inc(drops_total);
  end
`endif

endmodule

// File: doc/drop_timer.md
Name: drop_timer

Overview:
- Consumer end of the 1 kHz timebase: counts `tick1k` strobes from the clock generator and schedules gravity drops for the falling piece.
- Interval shrinks with game level; soft-drop shortens it further.
- Issues `drop_req` to the game FSM with a req/ack handshake, and a `lock_req` pulse after a lock delay once the piece has landed.
- Sits between the clock generator and the game-logic FSM, in the `clk50` domain.

Parameters:
- LEVEL_W, 4, width of level input
- BASE_MS, 1000, drop interval at level 0 (ms)
- STEP_MS, 75, interval reduction per level (ms)
- MIN_MS, 100, floor on level-derived interval (ms)
- SOFT_MS, 50, interval cap while soft_drop is high (ms)
- LOCK_MS, 500, lock delay after landing (ms)

Ports:
- clk50  in  1  system clock, 50 MHz
- rst_n  in  1  synchronous reset, active-low
- tick1k  in  1  1-cycle strobe every 1 ms
- run  in  1  game active; low forces IDLE
- pause  in  1  freeze counting; state and outputs held
- level  in  LEVEL_W  current level
- soft_drop  in  1  player holding down
- landed  in  1  piece resting on stack or floor
- drop_ack  in  1  game FSM consumed the drop
- drop_req  out  1  drop request, held until acked
- lock_req  out  1  1-cycle pulse: lock piece now

Behaviour:
- One clock (clk50); reset is synchronous and active-low (rst_n sampled on clk50 rising edge).
- Reset: state=IDLE, ms_cnt=0, drop_req=0, lock_req=0.
- Interval, combinational, 16-bit arithmetic:
  - lv_ms = BASE_MS - level*STEP_MS, saturating at 0 on underflow.
  - iv = max(lv_ms, MIN_MS).
  - If soft_drop: iv = min(iv, SOFT_MS).
  - Re-evaluated every cycle; a mid-count change of level or soft_drop applies immediately.
- ms_cnt: 16-bit; advances only on cycles with tick1k=1, pause=0, and state COUNT or LOCK.
- States:
  - IDLE:
    - Outputs 0, ms_cnt=0.
    - run=1 → COUNT.
  - COUNT:
    - landed=1 → LOCK, ms_cnt=0. This has priority over an interval expiry in the same cycle.
    - Else, on a counted tick with ms_cnt+1 >= iv → REQ, ms_cnt=0, drop_req=1 from the next cycle.
    - Else, on a counted tick, ms_cnt+1.
  - REQ:
    - drop_req held high.
    - tick1k ignored; ticks are not accumulated.
    - drop_ack=1 sampled → COUNT, drop_req=0 the next cycle, ms_cnt=0.
    - pause does not withdraw drop_req.
  - LOCK:
    - landed=0 → COUNT, ms_cnt=0 (piece slid off the edge).
    - Else, on a counted tick with ms_cnt+1 >= LOCK_MS → lock_req=1 for exactly one cycle, → COUNT, ms_cnt=0.
- Latency: the drop_req rising edge is 1 cycle after the expiring tick. drop_ack may be held high any number of cycles; only the first sampled cycle counts.
- drop_ack while not in REQ: ignored.
- run=0 in any state → IDLE next cycle, drop_req and lock_req cleared. This overrides a pending handshake.
- rst_n low mid-operation → reset values next edge, regardless of state.
- ms_cnt already >= a newly reduced iv → fires on the next counted tick.

Optional Feature:
- Macro DROP_TIMER_STATS_EN.
- Defined:
  - Extra output drops_total[15:0], reset 0.
  - Increments on each acknowledged drop (REQ→COUNT on drop_ack); saturates at 0xFFFF.
  - Cleared when state enters IDLE.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- level=0, run=1, tick1k every 4 clocks, no ack → drop_req rises 1 cycle after the 1000th tick and stays high; ticks 1001–1100 produce no change.
- level=5, then level=13, then level=15 → drops after 625, 100 and 100 ticks (13×75 clamps to MIN_MS; 15×75=1125 underflows → 100).
- level=0, soft_drop=1 at tick 30 → drop_req after tick 50. soft_drop=1 asserted at tick 70 → drop_req after the next tick (tick 71).
- landed=1 at tick 300 → no drop_req; lock_req one-cycle pulse after 500 further ticks. landed dropped at lock tick 200 → back to COUNT, next drop_req 1000 ticks later.
- pause=1 for 400 ticks mid-count at ms_cnt=600 → drop_req after 400 more unpaused ticks. pause during REQ → drop_req stays 1 until ack.
- rst_n=0 one cycle while in REQ → drop_req=0 the next cycle, IDLE; with run=1 the next drop occurs after a full 1000 ticks. [STATS_EN] 3 acked drops → drops_total=3.
